// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic family.
// Purpose : state encoding and sizing helpers reused by the serial subtractor
//           and by future serial blocks (serial adder, serial comparator).
// Contents: S_IDLE/S_SHIFT/S_DONE encodings, the state enum built on them,
//           and cnt_width() which sizes the bit counter (minimum one bit).
package serial_subtractor_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_e;

  // $clog2(1) is 0, but a zero-width counter is not representable.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell.
// Purpose : computes a - b - bi for single bits.
// Ports   : a, b, bi (inputs)  -> d (difference bit), bo (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Borrow is generated when a=0,b=1 and propagated when a==b.
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - bin, one bit per clock, LSB first.
// Purpose : area-minimal subtraction using a single full-subtractor cell
//           iterated over W cycles with a borrow flip-flop.
// Ports   : clk, rst (async, active-high)
//           start, A[W-1:0], B[W-1:0], bin  - request and operands
//           busy  - high during the W processing cycles
//           done  - one-cycle pulse when D/bout carry a fresh result
//           D[W-1:0], bout - difference and borrow-out, held until replaced
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] D,
  output logic         bout
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e        state;
  state_e        next_state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  res;
  logic [W-1:0]  res_shifted;
  logic          borrow;
  logic          d_bit;
  logic          bo_bit;
  logic          last_bit;

  full_subtractor u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (borrow),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign last_bit = (cnt == LAST);

  // The new difference bit enters at the MSB so after W shifts the
  // LSB-first stream lines up in natural bit order.
  if (W == 1) begin : g_res_w1
    assign res_shifted = d_bit;
  end else begin : g_res_wn
    assign res_shifted = {d_bit, res[W-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A new request is accepted from IDLE or straight out of DONE, which
  // allows back-to-back operations with no idle gap.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = start ? ST_SHIFT : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // D and bout are separate from the working result register so they keep
  // the previous answer while a new operation is being processed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      D      <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            borrow <= bin;
            cnt    <= '0;
            res    <= '0;
          end
        end
        ST_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bo_bit;
          res    <= res_shifted;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            D    <= res_shifted;
            bout <= bo_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor. Computes D = A - B - bin over W clock cycles, LSB first, using a single one-bit full-subtractor cell and a borrow flip-flop.
- It is the inverse-operation, area-minimal companion to the team's combinational ripple-carry adder.
- It sits in datapaths where subtraction latency is acceptable and gate count matters.
- Control is a start/busy/done handshake.

Parameters:
- W, 4, operand and result width in bits; legal range W >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high. Clears all state immediately.
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- A  input  W  minuend (unsigned); sampled in the cycle start is accepted.
- B  input  W  subtrahend (unsigned); sampled with A.
- bin  input  1  borrow-in; sampled with A.
- busy  output  1  high while a subtraction is in progress (SHIFT state).
- done  output  1  one-cycle pulse; D and bout are valid in this cycle.
- D  output  W  difference, (A - B - bin) mod 2^W.
- bout  output  1  borrow-out; 1 iff A < B + bin (unsigned compare).

Behaviour:
- Reset values: busy=0, done=0, D=0, bout=0. State=IDLE, counter=0, borrow flop=0, operand shift registers=0.
- States:
  - IDLE: waiting for start.
  - SHIFT: one bit processed per cycle.
  - DONE: single cycle, done=1.
- IDLE -> SHIFT on start=1. The same edge loads:
  - a_sr <= A, b_sr <= B, borrow <= bin, cnt <= 0.
  - Result shift register is cleared.
- In each SHIFT cycle, using a0 = a_sr[0] and b0 = b_sr[0]:
  - d = a0 ^ b0 ^ borrow.
  - borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow).
  - d shifts into the result MSB; the result shifts right.
  - a_sr and b_sr shift right by one; cnt increments.
- SHIFT -> DONE when cnt == W-1 on the processing edge. Exactly W SHIFT cycles occur.
- DONE: done=1 for exactly one cycle. D = result register; bout = borrow flop.
- DONE -> IDLE if start=0. DONE -> SHIFT if start=1, accepting a new operation back-to-back.
- Latency: start high in cycle 0 gives busy=1 in cycles 1..W and done=1 in cycle W+1.
  - Maximum throughput is one result per W+1 cycles.
- D and bout hold their last values after done until the next result is produced. They are not cleared on a new start.
- start while busy=1 is ignored. No queueing and no error flag.
- A, B and bin may change freely after the accepting edge; only the sampled values matter.
- Asynchronous rst at any time, including mid-SHIFT:
  - All outputs go to 0 immediately; state returns to IDLE.
  - A partial result is discarded; no done pulse is produced.
- busy and done are never high together.
- Counter width is $clog2(W) with a minimum of 1 bit.
- W=1 is legal: one SHIFT cycle, then DONE.

Decomposition:
- Shared constants header/package:
  - State encoding localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - Reused by future serial arithmetic blocks (serial adder, serial comparator).
- One natural sub-module, full_subtractor:
  - Combinational one-bit cell; ports d, bo, a, b, bi.
  - Instantiated once and iterated in time.
- FSM, counter and shift registers live in serial_subtractor.

Test Plan (all at W=4):
- A=9, B=3, bin=0, start pulse at cycle 0 -> busy high in cycles 1-4, done in cycle 5, D=6, bout=0.
- A=3, B=9, bin=0 -> D=4'hA, bout=1.
- A=0, B=0, bin=1 -> D=4'hF, bout=1. Then A=15, B=15, bin=1 -> D=4'hF, bout=1. Then A=15, B=0, bin=0 -> D=4'hF, bout=0.
- Start (A=9, B=3) held high continuously, with inputs changed to A=1, B=2 during busy -> only A=9, B=3 are used, giving D=6.
  - Start asserted again in the done cycle with A=5, B=5, bin=0 -> accepted. A second done arrives 5 cycles later with D=0, bout=0.
- rst asserted asynchronously mid-SHIFT (cycle 2, between clock edges) -> busy, done, D and bout drop to 0 immediately. No done pulse follows.
  - A fresh start with A=7, B=2 -> D=5, bout=0 at the normal latency.
- Randomized sweep of all 512 (A, B, bin) combinations -> D and bout match (A - B - bin) mod 16 and the unsigned borrow. done pulses exactly once per accepted start.
